mc_mips_core: RTL and testbench
===============================

MC_MIPS_CORE -- requirements
Module: mc_mips_core

Interface
REQ-001 Parameters SHALL be: RESET_PC, default 32'h0000_0000, first fetch address; EN_BNE, default 1, enables bne decode; EN_SHIFT, default 1, enables sll/srl decode.
REQ-002 Clock and reset SHALL be a single clock and an asynchronous, active-high reset: clk_i  in  1  rising-edge clock; reset_i  in  1  async active-high reset.
REQ-003 mem_req_o  out  1  memory access request, held until accepted.
REQ-004 mem_we_o  out  1  write strobe, valid while mem_req_o=1.
REQ-005 mem_addr_o  out  32  byte address, word-aligned.
REQ-006 mem_wdata_o  out  32  store data.
REQ-007 mem_rdata_i  in  32  read data, valid in the cycle mem_ready_i=1.
REQ-008 mem_ready_i  in  1  access accepted/completed this cycle.
REQ-009 pc_o  out  32  architectural PC.
REQ-010 retire_o  out  1  one-cycle pulse on the final cycle of each instruction.
REQ-011 illegal_o  out  1  one-cycle pulse in DECODE on an unsupported opcode or funct.

Function
REQ-012 The core SHALL be a multicycle MIPS subset sharing one memory port for instruction and data.
REQ-013 Supported instructions SHALL be:
- R-type (op 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; sll 0x00 and srl 0x02 only when EN_SHIFT=1.
- lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- bne 0x05 only when EN_BNE=1.
REQ-014 FSM states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP.
REQ-015 FETCH SHALL drive mem_req_o=1, mem_we_o=0, mem_addr_o=pc_o.
- On mem_ready_i=1: latch IR<=mem_rdata_i, pc<=pc+4, go to DECODE.
- Otherwise: stay in FETCH with address unchanged.
REQ-016 DECODE SHALL latch A<=rs and B<=rt, latch ALUOut<=pc+(signext(imm)<<2), then dispatch by opcode:
- lw/sw -> MEMADR; R-type -> EXEC; addi -> ADDIEX; beq/bne -> BRANCH; j -> JUMP.
- Illegal opcode or funct -> FETCH, with illegal_o=1 and no state update.
REQ-017 MEMADR SHALL compute ALUOut<=A+signext(imm), then go to MEMRD (lw) or MEMWR (sw).
REQ-018 MEMRD and MEMWR SHALL drive mem_req_o=1, mem_addr_o=ALUOut, and hold until mem_ready_i=1.
- MEMWR: mem_we_o=1 and mem_wdata_o=B; on accept, retire and go to FETCH.
- MEMRD: on accept, latch Data<=mem_rdata_i and go to MEMWB.
REQ-019 MEMWB SHALL write rt<=Data, retire, and go to FETCH.
REQ-020 EXEC SHALL compute ALUOut from A and B per funct.
- sll/srl: operand is B, shift amount is IR[10:6].
- slt: signed compare, result 0 or 1.
- Arithmetic wraps modulo 2^32; no overflow trap.
REQ-021 ALUWB SHALL write rd<=ALUOut and retire. ADDIEX SHALL compute ALUOut<=A+signext(imm). ADDIWB SHALL write rt<=ALUOut and retire.
REQ-022 BRANCH SHALL load pc<=ALUOut if (A==B) for beq or (A!=B) for bne, then retire.
REQ-023 JUMP SHALL load pc<={pc[31:28], IR[25:0], 2'b00} and retire.
REQ-024 Latency with mem_ready_i tied high SHALL be: beq/bne/j 3 cycles; R-type/addi/sw 4; lw 5. Each wait state adds exactly one cycle.
REQ-025 Register $0 SHALL read as zero; writes to $0 SHALL be discarded.
REQ-026 Register writes SHALL take effect at the clock edge ending the write-back state and be visible to the next instruction's DECODE.
REQ-027 mem_req_o SHALL be 0 in all states other than FETCH, MEMRD and MEMWR.
REQ-028 mem_addr_o, mem_we_o and mem_wdata_o SHALL remain stable while mem_req_o=1 and mem_ready_i=0.

Reset
REQ-029 On reset_i=1 the core SHALL asynchronously set pc<=RESET_PC, state<=FETCH, and IR, A, B, ALUOut, Data and all 32 registers to 0.
REQ-030 Reset outputs SHALL be mem_req_o=0, mem_we_o=0, retire_o=0, illegal_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-031 Reset asserted mid-access SHALL abandon the access. The first request after deassertion SHALL be a fetch from RESET_PC.

Structure
REQ-032 Package mc_mips_pkg SHALL hold: the state enum, opcode and funct constants, the ALU-operation enum, and the signext/shift helper functions.
REQ-033 The FSM SHALL be a separate sub-module, mc_controller: inputs state, opcode, funct and the A==B flag; outputs all datapath enables and mux selects. Register file, ALU and muxes SHALL be inline in mc_mips_core.

Verification
REQ-034 The bench SHALL cover the following scenarios:
- Zero-wait program {addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,8($0); lw $4,8($0)} -> mem[8]=12, $4=12, 21 cycles from first fetch, 5 retire pulses.
- beq $1,$1,+2 at 0x10 -> next fetch 0x1C. bne $1,$1,+2 at 0x10 -> next fetch 0x14. With EN_BNE=0, bne -> illegal_o pulse and fetch of 0x14.
- j 0x0000040 at 0x8000_0000 -> next fetch 0x8000_0100.
- mem_ready_i low for 3 cycles during FETCH and MEMRD of lw -> address and we stable throughout, lw completes in 11 cycles.
- addi $0,$0,9; add $5,$0,$0 -> $5=0. sll $6,$1,4 with $1=5 -> $6=80. slt with $1=-1, $2=1 -> 1.
- reset_i pulsed in MEMWR with ready low -> no write committed, mem_req_o=0 during reset, next request is a fetch from RESET_PC.

Source files
------------

// File: rtl/mc_mips_pkg.sv
// Shared types, opcode/funct constants and helpers for the multicycle MIPS core.
package mc_mips_pkg;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
        StExec, StAluWb, StAddiEx, StAddiWb, StBranch, StJump
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnSrl = 6'h02;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluSll, AluSrl} alu_op_e;

    typedef enum logic [1:0] {PcInc, PcBranch, PcJump} pc_sel_e;

    function automatic logic [31:0] signext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] shl2(input logic [31:0] v);
        return {v[29:0], 2'b00};
    endfunction

    function automatic logic [31:0] shift_op(input logic [31:0] v, input logic [4:0] sh,
                                             input logic left);
        return left ? (v << sh) : (v >> sh);
    endfunction

endpackage

// File: rtl/mc_controller.sv
// Multicycle control FSM: next-state logic plus every datapath enable and mux select.
module mc_controller
    import mc_mips_pkg::*;
#(
    parameter bit EN_BNE   = 1'b1,
    parameter bit EN_SHIFT = 1'b1
) (
    input  state_e      state_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    input  logic        a_eq_b_i,
    input  logic        mem_ready_i,
    output state_e      state_d_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        addr_alu_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output pc_sel_e     pc_sel_o,
    output logic        ab_we_o,
    output logic        aluout_we_o,
    output logic        aluout_br_o,
    output alu_op_e     alu_op_o,
    output logic        alu_b_imm_o,
    output logic        data_we_o,
    output logic        rf_we_o,
    output logic        rf_dst_rd_o,
    output logic        rf_src_data_o,
    output logic        retire_o,
    output logic        illegal_o
);

    logic    r_legal;
    alu_op_e r_op;

    // R-type funct decode; shifts are only legal when the shifter is enabled.
    always_comb begin
        r_legal = 1'b1;
        r_op    = AluAdd;
        case (funct_i)
            FnAdd:   r_op = AluAdd;
            FnSub:   r_op = AluSub;
            FnAnd:   r_op = AluAnd;
            FnOr:    r_op = AluOr;
            FnSlt:   r_op = AluSlt;
            FnSll:   begin r_op = AluSll; r_legal = EN_SHIFT; end
            FnSrl:   begin r_op = AluSrl; r_legal = EN_SHIFT; end
            default: r_legal = 1'b0;
        endcase
    end

    // Next state and per-state control outputs.
    always_comb begin
        state_d_o     = state_i;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        addr_alu_o    = 1'b0;
        ir_we_o       = 1'b0;
        pc_we_o       = 1'b0;
        pc_sel_o      = PcInc;
        ab_we_o       = 1'b0;
        aluout_we_o   = 1'b0;
        aluout_br_o   = 1'b0;
        alu_op_o      = AluAdd;
        alu_b_imm_o   = 1'b0;
        data_we_o     = 1'b0;
        rf_we_o       = 1'b0;
        rf_dst_rd_o   = 1'b0;
        rf_src_data_o = 1'b0;
        retire_o      = 1'b0;
        illegal_o     = 1'b0;
        unique case (state_i)
            StFetch: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o   = 1'b1;
                    pc_we_o   = 1'b1;
                    state_d_o = StDecode;
                end
            end
            StDecode: begin
                ab_we_o     = 1'b1;
                aluout_we_o = 1'b1;
                aluout_br_o = 1'b1;
                if (opcode_i == OpLw || opcode_i == OpSw) begin
                    state_d_o = StMemAdr;
                end else if (opcode_i == OpRtype && r_legal) begin
                    state_d_o = StExec;
                end else if (opcode_i == OpAddi) begin
                    state_d_o = StAddiEx;
                end else if (opcode_i == OpBeq || (opcode_i == OpBne && EN_BNE)) begin
                    state_d_o = StBranch;
                end else if (opcode_i == OpJ) begin
                    state_d_o = StJump;
                end else begin
                    // Unsupported encoding: drop it without touching any register.
                    ab_we_o     = 1'b0;
                    aluout_we_o = 1'b0;
                    illegal_o   = 1'b1;
                    state_d_o   = StFetch;
                end
            end
            StMemAdr: begin
                alu_b_imm_o = 1'b1;
                aluout_we_o = 1'b1;
                state_d_o   = (opcode_i == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_req_o  = 1'b1;
                addr_alu_o = 1'b1;
                if (mem_ready_i) begin
                    data_we_o = 1'b1;
                    state_d_o = StMemWb;
                end
            end
            StMemWb: begin
                rf_we_o       = 1'b1;
                rf_src_data_o = 1'b1;
                retire_o      = 1'b1;
                state_d_o     = StFetch;
            end
            StMemWr: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                addr_alu_o = 1'b1;
                if (mem_ready_i) begin
                    retire_o  = 1'b1;
                    state_d_o = StFetch;
                end
            end
            StExec: begin
                alu_op_o    = r_op;
                aluout_we_o = 1'b1;
                state_d_o   = StAluWb;
            end
            StAluWb: begin
                rf_we_o     = 1'b1;
                rf_dst_rd_o = 1'b1;
                retire_o    = 1'b1;
                state_d_o   = StFetch;
            end
            StAddiEx: begin
                alu_b_imm_o = 1'b1;
                aluout_we_o = 1'b1;
                state_d_o   = StAddiWb;
            end
            StAddiWb: begin
                rf_we_o   = 1'b1;
                retire_o  = 1'b1;
                state_d_o = StFetch;
            end
            StBranch: begin
                if ((opcode_i == OpBne) ? !a_eq_b_i : a_eq_b_i) begin
                    pc_we_o  = 1'b1;
                    pc_sel_o = PcBranch;
                end
                retire_o  = 1'b1;
                state_d_o = StFetch;
            end
            StJump: begin
                pc_we_o   = 1'b1;
                pc_sel_o  = PcJump;
                retire_o  = 1'b1;
                state_d_o = StFetch;
            end
            default: state_d_o = StFetch;
        endcase
    end

endmodule

// File: rtl/mc_mips_core.sv
// Multicycle MIPS subset core: register file, ALU and datapath muxes around mc_controller.
module mc_mips_core
    import mc_mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          EN_BNE   = 1'b1,
    parameter bit          EN_SHIFT = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic [31:0] pc_o,
    output logic        retire_o,
    output logic        illegal_o
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, ir_q, a_q, b_q, aluout_q, data_q;
    logic [31:0] rf_q [32];

    logic        c_mem_req, c_mem_we, addr_alu, ir_we, pc_we, ab_we, aluout_we, aluout_br;
    logic        alu_b_imm, data_we, rf_we, rf_dst_rd, rf_src_data, c_retire, c_illegal;
    pc_sel_e     pc_sel;
    alu_op_e     alu_op;

    logic [4:0]  rs, rt, rd, rf_waddr;
    logic [31:0] rs_val, rt_val, alu_b, alu_res, aluout_d, pc_d, rf_wdata, imm_ext;

    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign imm_ext  = signext(ir_q[15:0]);
    assign rs_val   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : rf_q[rt];
    assign alu_b    = alu_b_imm ? imm_ext : b_q;
    assign aluout_d = aluout_br ? (pc_q + shl2(imm_ext)) : alu_res;
    assign rf_waddr = rf_dst_rd ? rd : rt;
    assign rf_wdata = rf_src_data ? data_q : aluout_q;

    mc_controller #(
        .EN_BNE   (EN_BNE),
        .EN_SHIFT (EN_SHIFT)
    ) u_ctrl (
        .state_i       (state_q),
        .opcode_i      (ir_q[31:26]),
        .funct_i       (ir_q[5:0]),
        .a_eq_b_i      (a_q == b_q),
        .mem_ready_i   (mem_ready_i),
        .state_d_o     (state_d),
        .mem_req_o     (c_mem_req),
        .mem_we_o      (c_mem_we),
        .addr_alu_o    (addr_alu),
        .ir_we_o       (ir_we),
        .pc_we_o       (pc_we),
        .pc_sel_o      (pc_sel),
        .ab_we_o       (ab_we),
        .aluout_we_o   (aluout_we),
        .aluout_br_o   (aluout_br),
        .alu_op_o      (alu_op),
        .alu_b_imm_o   (alu_b_imm),
        .data_we_o     (data_we),
        .rf_we_o       (rf_we),
        .rf_dst_rd_o   (rf_dst_rd),
        .rf_src_data_o (rf_src_data),
        .retire_o      (c_retire),
        .illegal_o     (c_illegal)
    );

    // ALU; shifts take B as operand and IR[10:6] as the amount.
    always_comb begin
        alu_res = 32'd0;
        case (alu_op)
            AluAdd:  alu_res = a_q + alu_b;
            AluSub:  alu_res = a_q - alu_b;
            AluAnd:  alu_res = a_q & alu_b;
            AluOr:   alu_res = a_q | alu_b;
            AluSlt:  alu_res = {31'd0, $signed(a_q) < $signed(alu_b)};
            AluSll:  alu_res = shift_op(b_q, ir_q[10:6], 1'b1);
            AluSrl:  alu_res = shift_op(b_q, ir_q[10:6], 1'b0);
            default: alu_res = 32'd0;
        endcase
    end

    // PC source select.
    always_comb begin
        pc_d = pc_q + 32'd4;
        case (pc_sel)
            PcBranch: pc_d = aluout_q;
            PcJump:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
            default:  pc_d = pc_q + 32'd4;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= StFetch;
        else         state_q <= state_d;
    end

    // Architectural and internal datapath registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
            data_q   <= 32'd0;
        end else begin
            if (pc_we)     pc_q     <= pc_d;
            if (ir_we)     ir_q     <= mem_rdata_i;
            if (ab_we)     a_q      <= rs_val;
            if (ab_we)     b_q      <= rt_val;
            if (aluout_we) aluout_q <= aluout_d;
            if (data_we)   data_q   <= mem_rdata_i;
        end
    end

    // Register file; writes to $0 are dropped.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // Outputs forced quiet while reset is held so an in-flight access is abandoned.
    assign mem_req_o   = c_mem_req & ~reset_i;
    assign mem_we_o    = c_mem_we & ~reset_i;
    assign mem_addr_o  = reset_i ? 32'd0 : (addr_alu ? aluout_q : pc_q);
    assign mem_wdata_o = reset_i ? 32'd0 : b_q;
    assign retire_o    = c_retire & ~reset_i;
    assign illegal_o   = c_illegal & ~reset_i;
    assign pc_o        = pc_q;

endmodule

// File: tb/tb_mc_mips_core.sv
// Self-checking bench for mc_mips_core: table of single-instruction vectors plus
// hand-written sequences for branches, jumps, wait states, $0 and reset.
module tb_mc_mips_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req, we, ready, retire, illegal;
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [31:0] pc [3];
    logic [31:0] mem [3][256];

    int checks = 0;
    int errors = 0;
    int ret_cyc [16];

    always #5 clk = ~clk;

    mc_mips_core #(.RESET_PC(32'h0000_0000), .EN_BNE(1'b1), .EN_SHIFT(1'b1)) dut_a (
        .clk_i(clk), .reset_i(reset), .mem_req_o(req[0]), .mem_we_o(we[0]),
        .mem_addr_o(addr[0]), .mem_wdata_o(wdata[0]), .mem_rdata_i(rdata[0]),
        .mem_ready_i(ready[0]), .pc_o(pc[0]), .retire_o(retire[0]), .illegal_o(illegal[0])
    );

    mc_mips_core #(.RESET_PC(32'h8000_0000), .EN_BNE(1'b1), .EN_SHIFT(1'b1)) dut_b (
        .clk_i(clk), .reset_i(reset), .mem_req_o(req[1]), .mem_we_o(we[1]),
        .mem_addr_o(addr[1]), .mem_wdata_o(wdata[1]), .mem_rdata_i(rdata[1]),
        .mem_ready_i(ready[1]), .pc_o(pc[1]), .retire_o(retire[1]), .illegal_o(illegal[1])
    );

    mc_mips_core #(.RESET_PC(32'h0000_0010), .EN_BNE(1'b0), .EN_SHIFT(1'b0)) dut_c (
        .clk_i(clk), .reset_i(reset), .mem_req_o(req[2]), .mem_we_o(we[2]),
        .mem_addr_o(addr[2]), .mem_wdata_o(wdata[2]), .mem_rdata_i(rdata[2]),
        .mem_ready_i(ready[2]), .pc_o(pc[2]), .retire_o(retire[2]), .illegal_o(illegal[2])
    );

    // Word memories, 1 KiB each, aliased on address bits [9:2].
    always_comb begin
        for (int k = 0; k < 3; k++) rdata[k] = mem[k][addr[k][9:2]];
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            if (req[k] && we[k] && ready[k]) mem[k][addr[k][9:2]] <= wdata[k];
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mem(input int k);
        for (int i = 0; i < 256; i++) mem[k][i] = 32'd0;
    endtask

    // Leaves the bench just after a clock edge, so the next negedge samples cycle 1.
    task automatic reset_dut;
        reset = 1'b1;
        ready = 3'b111;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_retires(input int k, input int n, input int budget, input string name);
        int cnt = 0;
        int cyc = 0;
        for (int i = 0; i < 16; i++) ret_cyc[i] = 0;
        while (cnt < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (retire[k]) begin
                cnt++;
                ret_cyc[cnt] = cyc;
            end
        end
        if (cnt < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d retires expected %0d", name, cnt, n);
        end
    endtask

    task automatic branch_seq(input string name, input logic [31:0] instr,
                              input logic [31:0] exp_addr);
        clear_mem(0);
        mem[0][0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
        mem[0][1] = enc_j(26'h4);
        mem[0][4] = instr;
        reset_dut();
        run_retires(0, 3, 40, name);
        check({name, " latency"}, ret_cyc[3] - ret_cyc[2], 32'd3);
        @(negedge clk);
        check({name, " req"}, {31'd0, req[0] & ~we[0]}, 32'd1);
        check({name, " next fetch"}, addr[0], exp_addr);
    endtask

    typedef struct {
        string       name;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [31:0] instr;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    task automatic set_vec(input int i, input string name, input logic [15:0] v1,
                           input logic [15:0] v2, input logic [31:0] instr,
                           input logic [31:0] exp);
        vecs[i].name  = name;
        vecs[i].v1    = v1;
        vecs[i].v2    = v2;
        vecs[i].instr = instr;
        vecs[i].exp   = exp;
        vecs[i].lat   = 4;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_acc, in_acc, waits, bad_stable, cyc, done;
        logic [31:0] acc_addr [4];
        logic        acc_we [4];
        logic [31:0] cur_addr;
        logic        cur_we;

        // Vectors: $1<=v1, $2<=v2, then instr writing $3, stored to 0x80.
        set_vec(0,  "add",      16'd5,     16'd7,     enc_r(1, 2, 3, 0, 6'h20), 32'd12);
        set_vec(1,  "sub",      16'd5,     16'd7,     enc_r(1, 2, 3, 0, 6'h22), 32'hFFFF_FFFE);
        set_vec(2,  "and",      16'h0F0F,  16'h00FF,  enc_r(1, 2, 3, 0, 6'h24), 32'h0000_000F);
        set_vec(3,  "or",       16'h0F00,  16'h00F0,  enc_r(1, 2, 3, 0, 6'h25), 32'h0000_0FF0);
        set_vec(4,  "slt_neg",  16'hFFFF,  16'd1,     enc_r(1, 2, 3, 0, 6'h2A), 32'd1);
        set_vec(5,  "slt_pos",  16'd1,     16'hFFFF,  enc_r(1, 2, 3, 0, 6'h2A), 32'd0);
        set_vec(6,  "sll",      16'd5,     16'd0,     enc_r(0, 1, 3, 4, 6'h00), 32'd80);
        set_vec(7,  "srl",      16'hFFFF,  16'd0,     enc_r(0, 1, 3, 4, 6'h02), 32'h0FFF_FFFF);
        set_vec(8,  "addi_neg", 16'd5,     16'd0,     enc_i(6'h08, 1, 3, 16'hFFFD), 32'd2);
        set_vec(9,  "add_wrap", 16'hFFFF,  16'd1,     enc_r(1, 2, 3, 0, 6'h20), 32'd0);
        set_vec(10, "or_sext",  16'h8000,  16'd1,     enc_r(1, 2, 3, 0, 6'h25), 32'hFFFF_8001);

        for (int k = 0; k < 3; k++) clear_mem(k);
        ready = 3'b111;

        // Reset state of the core with a nonzero reset PC.
        repeat (2) @(negedge clk);
        check("reset req", {31'd0, req[1]}, 32'd0);
        check("reset we", {31'd0, we[1]}, 32'd0);
        check("reset addr", addr[1], 32'd0);
        check("reset wdata", wdata[1], 32'd0);
        check("reset retire/illegal", {30'd0, retire[1], illegal[1]}, 32'd0);
        check("reset pc", pc[1], 32'h8000_0000);

        // Jump keeps PC[31:28].
        mem[1][0] = enc_j(26'h40);
        reset_dut();
        @(negedge clk);
        check("first fetch req", {31'd0, req[1]}, 32'd1);
        check("first fetch addr", addr[1], 32'h8000_0000);
        run_retires(1, 1, 10, "j");
        check("j latency", ret_cyc[1], 32'd2);
        @(negedge clk);
        check("j next fetch", addr[1], 32'h8000_0100);

        // Table-driven single-instruction vectors.
        for (int i = 0; i < 11; i++) begin
            clear_mem(0);
            mem[0][0]  = enc_i(6'h08, 0, 1, vecs[i].v1);
            mem[0][1]  = enc_i(6'h08, 0, 2, vecs[i].v2);
            mem[0][2]  = vecs[i].instr;
            mem[0][3]  = enc_i(6'h2B, 0, 3, 16'h0080);
            mem[0][4]  = enc_j(26'h4);
            mem[0][32] = 32'hDEAD_BEEF;
            reset_dut();
            run_retires(0, 4, 40, vecs[i].name);
            @(negedge clk);
            check({vecs[i].name, " result"}, mem[0][32], vecs[i].exp);
            check({vecs[i].name, " latency"}, ret_cyc[3] - ret_cyc[2], vecs[i].lat);
        end

        // Zero-wait program with store/load round trip.
        clear_mem(0);
        mem[0][0] = enc_i(6'h08, 0, 1, 16'd5);
        mem[0][1] = enc_i(6'h08, 0, 2, 16'd7);
        mem[0][2] = enc_r(1, 2, 3, 0, 6'h20);
        mem[0][3] = enc_i(6'h2B, 0, 3, 16'd8);
        mem[0][4] = enc_i(6'h23, 0, 4, 16'd8);
        mem[0][5] = enc_i(6'h2B, 0, 4, 16'd16);
        mem[0][6] = enc_j(26'h6);
        reset_dut();
        run_retires(0, 6, 60, "program");
        check("program first retire", ret_cyc[1], 32'd4);
        check("program 5 retires cycles", ret_cyc[5], 32'd21);
        @(negedge clk);
        check("program mem[8]", mem[0][2], 32'd12);
        check("program $4", mem[0][4], 32'd12);

        // Branches at 0x10.
        branch_seq("beq taken", enc_i(6'h04, 1, 1, 16'd2), 32'h0000_001C);
        branch_seq("bne not taken", enc_i(6'h05, 1, 1, 16'd2), 32'h0000_0014);
        branch_seq("beq not taken", enc_i(6'h04, 1, 0, 16'd2), 32'h0000_0014);
        branch_seq("bne taken", enc_i(6'h05, 1, 0, 16'd2), 32'h0000_001C);
        branch_seq("beq backward", enc_i(6'h04, 1, 1, 16'hFFFC), 32'h0000_0004);

        // bne and sll decode as illegal with EN_BNE=0, EN_SHIFT=0.
        mem[2][4] = enc_i(6'h05, 1, 1, 16'd2);
        mem[2][5] = enc_r(0, 1, 3, 4, 6'h00);
        reset_dut();
        @(negedge clk);
        check("noben fetch addr", addr[2], 32'h0000_0010);
        @(negedge clk);
        check("bne illegal pulse", {30'd0, illegal[2], retire[2]}, 32'd2);
        @(negedge clk);
        check("after illegal req", {30'd0, req[2], illegal[2]}, 32'd2);
        check("after illegal fetch", addr[2], 32'h0000_0014);
        @(negedge clk);
        check("sll illegal pulse", {31'd0, illegal[2]}, 32'd1);
        @(negedge clk);
        check("after sll fetch", addr[2], 32'h0000_0018);

        // $0 is hardwired to zero.
        clear_mem(0);
        mem[0][0]  = enc_i(6'h08, 0, 5, 16'd7);
        mem[0][1]  = enc_i(6'h08, 0, 0, 16'd9);
        mem[0][2]  = enc_r(0, 0, 5, 0, 6'h20);
        mem[0][3]  = enc_i(6'h2B, 0, 5, 16'h0080);
        mem[0][4]  = enc_i(6'h2B, 0, 0, 16'h0084);
        mem[0][5]  = enc_j(26'h5);
        mem[0][32] = 32'hDEAD_BEEF;
        mem[0][33] = 32'hDEAD_BEEF;
        reset_dut();
        run_retires(0, 5, 40, "zero reg");
        @(negedge clk);
        check("$5 = $0+$0", mem[0][32], 32'd0);
        check("$0 store", mem[0][33], 32'd0);

        // Three wait cycles on the lw fetch and on its data read.
        clear_mem(0);
        mem[0][0]  = enc_i(6'h23, 0, 4, 16'h0040);
        mem[0][1]  = enc_i(6'h2B, 0, 4, 16'h0044);
        mem[0][2]  = enc_j(26'h2);
        mem[0][16] = 32'h1234_5678;
        reset_dut();
        n_acc = 0; in_acc = 0; waits = 0; bad_stable = 0; cyc = 0; done = 0;
        cur_addr = 32'd0; cur_we = 1'b0;
        for (int i = 0; i < 4; i++) begin acc_addr[i] = 32'hFFFF_FFFF; acc_we[i] = 1'b1; end
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (req[0]) begin
                if (in_acc == 0) begin
                    in_acc = 1;
                    waits = 0;
                    cur_addr = addr[0];
                    cur_we = we[0];
                    if (n_acc < 4) begin acc_addr[n_acc] = addr[0]; acc_we[n_acc] = we[0]; end
                    n_acc++;
                end else if (addr[0] !== cur_addr || we[0] !== cur_we) begin
                    bad_stable++;
                end
                if (n_acc <= 2 && waits < 3) begin
                    ready[0] = 1'b0;
                    waits++;
                end else begin
                    ready[0] = 1'b1;
                    in_acc = 0;
                end
            end
            if (retire[0]) done = 1;
        end
        ready[0] = 1'b1;
        check("wait lw cycles", cyc, 32'd11);
        check("wait stable", bad_stable, 32'd0);
        check("wait fetch addr", acc_addr[0], 32'h0000_0000);
        check("wait read addr", acc_addr[1], 32'h0000_0040);
        check("wait we low", {30'd0, acc_we[0], acc_we[1]}, 32'd0);
        run_retires(0, 1, 10, "wait sw");
        @(negedge clk);
        check("wait lw data", mem[0][17], 32'h1234_5678);

        // Reset during a stalled store abandons it.
        clear_mem(0);
        mem[0][0]  = enc_i(6'h08, 0, 3, 16'h0055);
        mem[0][1]  = enc_i(6'h2B, 0, 3, 16'h0080);
        mem[0][2]  = enc_j(26'h2);
        mem[0][32] = 32'hDEAD_BEEF;
        reset_dut();
        done = 0; cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (req[0] && we[0]) begin
                ready[0] = 1'b0;
                done = 1;
            end
        end
        check("memwr reached", done, 32'd1);
        @(negedge clk);
        check("memwr held addr", addr[0], 32'h0000_0080);
        check("memwr held data", wdata[0], 32'h0000_0055);
        reset = 1'b1;
        #1;
        check("mid reset outputs", {29'd0, req[0], we[0], retire[0]}, 32'd0);
        check("mid reset addr", addr[0], 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("reset held req", {31'd0, req[0]}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        ready[0] = 1'b1;
        @(negedge clk);
        check("post reset fetch", {30'd0, req[0], we[0]}, 32'd2);
        check("post reset addr", addr[0], 32'h0000_0000);
        check("store abandoned", mem[0][32], 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
